// File: rtl/fizzbuzz_sequencer.sv
// fizzbuzz_sequencer: walks 1..limit after a start command and emits one classified value per beat.
// Latency: first beat one cycle after start is accepted, then one beat per cycle while ready_i is high.
// Backpressure: valid/ready stream; the beat holds unchanged while ready_i is low; abort_i wins over a handshake.
//
// Ports:
//   clk_i, reset_i          rising-edge clock, asynchronous active-high reset
//   start_i, limit_i        run request (sampled only in IDLE) and last value to emit (latched on accept)
//   abort_i                 synchronous cancel of a run in progress (no done pulse)
//   ready_i / valid_o       downstream handshake for number_o and the print_* classification
//   busy_o                  high while a run is active
//   done_o                  one-cycle pulse after the final beat is accepted (or after a zero-limit start)
module fizzbuzz_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             abort_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] number_o,
  output logic             print_number_o,
  output logic             print_fizz_o,
  output logic             print_buzz_o,
  output logic             print_fizzbuzz_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // flag vector order: {fizzbuzz, buzz, fizz, number}
  state_t           state_q, state_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [1:0]       r3_q, r3_d;
  logic [2:0]       r5_q, r5_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [3:0]       flags_q, flags_d;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      number_q <= '0;
      limit_q  <= '0;
      r3_q     <= '0;
      r5_q     <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      number_q <= number_d;
      limit_q  <= limit_d;
      r3_q     <= r3_d;
      r5_q     <= r5_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    number_d = number_q;
    limit_d  = limit_q;
    r3_d     = r3_q;
    r5_d     = r5_q;
    valid_d  = valid_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (limit_i != '0) begin
            state_d  = RUN;
            limit_d  = limit_i;
            number_d = WIDTH'(1);
            r3_d     = 2'd1;
            r5_d     = 3'd1;
            valid_d  = 1'b1;
          end else begin
            // Empty run: acknowledge with done but never present a beat.
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (valid_q && ready_i) begin
          // Compare before incrementing so an all-ones limit never wraps.
          if (number_q == limit_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            number_d = number_q + WIDTH'(1);
            r3_d     = (r3_q == 2'd2) ? 2'd0 : r3_q + 2'd1;
            r5_d     = (r5_q == 3'd4) ? 3'd0 : r5_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Classification is registered alongside the value it describes.
    flags_d = 4'b0000;
    if (valid_d) begin
      if (r3_d == 2'd0 && r5_d == 3'd0) flags_d = 4'b1000;
      else if (r5_d == 3'd0)            flags_d = 4'b0100;
      else if (r3_d == 2'd0)            flags_d = 4'b0010;
      else                              flags_d = 4'b0001;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    valid_o          = valid_q;
    number_o         = number_q;
    print_fizzbuzz_o = flags_q[3];
    print_buzz_o     = flags_q[2];
    print_fizz_o     = flags_q[1];
    print_number_o   = flags_q[0];
    busy_o           = (state_q == RUN);
    done_o           = done_q;
  end

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// tb_fizzbuzz_sequencer: scoreboard bench for fizzbuzz_sequencer (32-bit instance plus a 4-bit instance).
// Expected beats are queued when a run is issued; a negedge monitor pops and compares each accepted beat.
// Also checks stall stability, one-hot flags, done/busy timing, abort, async reset and 4-bit no-wrap.
module tb_fizzbuzz_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort, ready;
  logic [W-1:0] limit;
  logic         valid, p_num, p_fizz, p_buzz, p_fb, busy, done;
  logic [W-1:0] number;

  logic         start4, abort4, ready4;
  logic [3:0]   limit4, number4;
  logic         valid4, p_num4, p_fizz4, p_buzz4, p_fb4, busy4, done4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] num;
    logic [3:0]  flags;   // {fizzbuzz, buzz, fizz, number}
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  fizzbuzz_sequencer #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .limit_i(limit), .abort_i(abort),
    .ready_i(ready), .valid_o(valid), .number_o(number), .print_number_o(p_num),
    .print_fizz_o(p_fizz), .print_buzz_o(p_buzz), .print_fizzbuzz_o(p_fb),
    .busy_o(busy), .done_o(done)
  );

  fizzbuzz_sequencer #(.WIDTH(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .start_i(start4), .limit_i(limit4), .abort_i(abort4),
    .ready_i(ready4), .valid_o(valid4), .number_o(number4), .print_number_o(p_num4),
    .print_fizz_o(p_fizz4), .print_buzz_o(p_buzz4), .print_fizzbuzz_o(p_fb4),
    .busy_o(busy4), .done_o(done4)
  );

  // Reference classifier written directly from the divisibility rules.
  function automatic logic [3:0] classify(input int unsigned n);
    if (n % 15 == 0)     return 4'b1000;
    else if (n % 5 == 0) return 4'b0100;
    else if (n % 3 == 0) return 4'b0010;
    else                 return 4'b0001;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every accepted beat against the scoreboard, and watch stalls.
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  always @(negedge clk) begin
    logic [3:0] fl;
    beat_t      e;
    fl = {p_fb, p_buzz, p_fizz, p_num};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (valid) check("onehot", 64'($countones(fl)), 64'd1);
      else       check("flags_idle", 64'(fl), 64'd0);
      if (prev_stall) check("stall_hold", {27'd0, valid, number, fl}, {27'd0, 1'b1, prev_beat});
      if (valid && ready && !abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(number), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", {28'd0, number, fl}, {28'd0, e});
        end
      end
      prev_stall = valid && !ready && !abort;
      prev_beat  = {number, fl};
    end
  end

  // Issue a start (called just after a rising edge) and queue the beats expected to be accepted.
  task automatic start_run(input int unsigned lim, input int unsigned npush);
    start = 1'b1;
    limit = lim;
    for (int unsigned i = 1; i <= npush; i++) exp_q.push_back({i, classify(i)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit rnd);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check({name, "_done"}, 64'(seen), 64'd1);
    check({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, beats4, bud;
    bit seen7, seen4;
    logic [3:0] last_fl4;
    rst = 1'b1; start = 0; abort = 0; ready = 0; limit = '0;
    start4 = 0; abort4 = 0; ready4 = 1'b1; limit4 = '0;
    #12;
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_number", 64'(number), 64'd0);
    check("reset_busy_done", {busy, done}, 64'd0);
    check("reset_flags", 64'({p_fb, p_buzz, p_fizz, p_num}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Limit 15 with ready held high
    ready = 1'b1;
    start_run(15, 15);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = c; end
      @(posedge clk); #1;
    end
    check("l15_busy_cycles", 64'(busy_cnt), 64'd15);
    check("l15_done_count", 64'(done_cnt), 64'd1);
    check("l15_done_cycle", 64'(done_at), 64'd15);
    check("l15_q_empty", 64'(exp_q.size()), 64'd0);

    // Limit 100 with random backpressure
    start_run(100, 100);
    wait_done("l100", 2000, 1'b1);

    // Limit 0, then an immediate start in the done cycle
    ready = 1'b1;
    start_run(0, 0);
    check("l0_done", 64'(done), 64'd1);
    check("l0_valid", 64'(valid), 64'd0);
    start_run(3, 3);
    check("l3_first_valid", 64'(valid), 64'd1);
    wait_done("l3", 20, 1'b0);

    // Start and limit changes during an active run are ignored
    start_run(10, 10);
    @(posedge clk); #1;
    start = 1'b1; limit = 5;
    @(posedge clk); #1;
    start = 1'b0; limit = 3;
    wait_done("l10", 50, 1'b0);

    // Abort at number 7 alongside ready
    @(posedge clk); #1;
    start_run(20, 6);
    seen7 = 1'b0;
    for (int c = 0; c < 40 && !seen7; c++) begin
      if (valid && number == 7) seen7 = 1'b1;
      else begin ready = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
    end
    check("abort_reached7", 64'(seen7), 64'd1);
    ready = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_busy_done", {busy, done}, 64'd0);
    @(posedge clk); #1;
    check("abort_no_done", 64'(done), 64'd0);
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset between edges in the middle of a stalled run
    ready = 1'b0;
    start_run(50, 0);
    @(posedge clk); #1;
    check("pre_reset_valid", 64'(valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("areset_valid", 64'(valid), 64'd0);
    check("areset_number", 64'(number), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_flags", 64'({p_fb, p_buzz, p_fizz, p_num}), 64'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // 4-bit instance, limit 15: ends at 15 as FizzBuzz without wrapping
    start4 = 1'b1; limit4 = 4'd15;
    @(posedge clk); #1;
    start4 = 1'b0;
    beats4 = 0; seen4 = 1'b0; last_fl4 = '0; bud = 0;
    while (!seen4 && bud < 40) begin
      if (valid4) begin
        beats4++;
        check("w4_number", 64'(number4), 64'(beats4));
        last_fl4 = {p_fb4, p_buzz4, p_fizz4, p_num4};
        check("w4_flags", 64'(last_fl4), 64'(classify(beats4)));
      end
      if (done4) seen4 = 1'b1;
      @(posedge clk); #1;
      bud++;
    end
    check("w4_done", 64'(seen4), 64'd1);
    check("w4_beats", 64'(beats4), 64'd15);
    check("w4_last_fb", 64'(last_fl4), 64'b1000);
    check("w4_no_wrap", {valid4, busy4}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
